// File: rtl/attex_bus_pkg.sv
// Shared types and helpers for the SCC68070 bus fabric.
package attex_bus_pkg;

  localparam int MAX_SLAVES = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    ERROR   = 2'd2,
    RELEASE = 2'd3
  } fabric_state_e;

  // Width of a slave index, never narrower than one bit.
  function automatic int slv_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Counter width: must hold the timeout value and any 4-bit minimum wait.
  function automatic int wdt_cnt_w(input int t);
    int w;
    w = $clog2(t + 1);
    return (w < 4) ? 4 : w;
  endfunction

  // Slice region i out of a packed 24-bit-per-region parameter.
  function automatic logic [23:0] region_word(input logic [MAX_SLAVES*24-1:0] v, input int i);
    return v[i*24 +: 24];
  endfunction

  // Slice region i out of a packed 4-bit-per-region parameter.
  function automatic logic [3:0] region_wait(input logic [MAX_SLAVES*4-1:0] v, input int i);
    return v[i*4 +: 4];
  endfunction

endpackage

// File: rtl/bus_timeout_wdt.sv
// Saturating cycle counter used for minimum wait states and the bus timeout.
module bus_timeout_wdt #(
  parameter int CNT_W   = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic       clk30,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] min_wait,
  output logic       min_reached,
  output logic       expired
);

  logic [CNT_W-1:0] cnt;

  // Count while enabled, stick at all-ones; clear wins over counting.
  always_ff @(posedge clk30) begin
    if (reset || clr)
      cnt <= '0;
    else if (en && (cnt != '1))
      cnt <= cnt + CNT_W'(1);
  end

  assign min_reached = (cnt >= CNT_W'(min_wait));
  // A zero timeout never expires.
  assign expired     = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/attex_bus_fabric.sv
// SCC68070 bus fabric: address decode, chip-selects, read mux, ack/bus-error.
// Optional error capture ports/registers are built when
// ATTEX_BUS_ERR_CAPTURE_EN is defined.
module attex_bus_fabric
  import attex_bus_pkg::*;
#(
  parameter int                          NUM_SLAVES     = 5,
  parameter logic [NUM_SLAVES*24-1:0]    REGION_BASE    = {5{24'h0}},
  parameter logic [NUM_SLAVES*24-1:0]    REGION_MASK    = {5{24'hff0000}},
  parameter logic [NUM_SLAVES-1:0]       BYTE_DUP       = 5'b00110,
  parameter logic [NUM_SLAVES*4-1:0]     MIN_WAIT       = {5{4'd0}},
  parameter int                          TIMEOUT_CYCLES = 1023,
  parameter int                          IACK_SLAVE     = 1
) (
  input  logic                       clk30,
  input  logic                       reset,
  input  logic [23:1]                cpu_addr,
  input  logic                       cpu_as,
  input  logic                       cpu_uds,
  input  logic                       cpu_lds,
  input  logic                       cpu_write_strobe,
  input  logic                       cpu_iack,
  output logic [15:0]                cpu_data_in,
  output logic                       cpu_bus_ack,
  output logic                       cpu_bus_err,
  output logic [NUM_SLAVES-1:0]      slave_cs,
  input  logic [NUM_SLAVES*16-1:0]   slave_dout,
  input  logic [NUM_SLAVES-1:0]      slave_ack,
  output logic                       fabric_busy
`ifdef ATTEX_BUS_ERR_CAPTURE_EN
  ,
  output logic [23:0]                err_addr,
  output logic                       err_was_timeout,
  output logic [7:0]                 err_count
`endif
);

  localparam int IDX_W = slv_idx_w(NUM_SLAVES);
  localparam int CNT_W = wdt_cnt_w(TIMEOUT_CYCLES);
  localparam logic [MAX_SLAVES*24-1:0] BASE_EXT = (MAX_SLAVES*24)'(REGION_BASE);
  localparam logic [MAX_SLAVES*24-1:0] MASK_EXT = (MAX_SLAVES*24)'(REGION_MASK);
  localparam logic [MAX_SLAVES*4-1:0]  WAIT_EXT = (MAX_SLAVES*4)'(MIN_WAIT);

  fabric_state_e                     state_q, state_d;
  logic [IDX_W-1:0]                  idx_q, idx_d, hit_idx;
  logic                              hit, strobe, wdt_clr, min_reached, expired, acc_ack;
  logic [23:0]                       addr_byte;
  logic [NUM_SLAVES-1:0]             match;
  logic [NUM_SLAVES-1:0][15:0]       dout_arr;
  logic [15:0]                       sel_raw, sel_data;
  // Direction does not affect decode or handshake; slaves see it directly.
  logic                              unused_wr;

  assign unused_wr = cpu_write_strobe;
  assign addr_byte = {cpu_addr, 1'b0};
  assign strobe    = cpu_uds || cpu_lds;
  assign dout_arr  = slave_dout;

  generate
    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_dec
      assign match[i] = cpu_as && ((addr_byte & region_word(MASK_EXT, i)) == region_word(BASE_EXT, i));
    end
  endgenerate

  // Priority encode: the lowest matching region wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  bus_timeout_wdt #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT_CYCLES)) u_wdt (
    .clk30       (clk30),
    .reset       (reset),
    .clr         (wdt_clr),
    .en          (state_q == ACCESS),
    .min_wait    (region_wait(WAIT_EXT, int'(idx_q))),
    .min_reached (min_reached),
    .expired     (expired)
  );

  // Ack from the latched slave, honoured only after its minimum wait and while AS holds.
  assign acc_ack = (state_q == ACCESS) && cpu_as && slave_ack[idx_q] && min_reached;

  // State and latched slave index.
  always_ff @(posedge clk30) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: IACK beats decode; dropping AS ends any cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wdt_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_iack)
          state_d = RELEASE;
        else if (cpu_as && strobe) begin
          if (hit) begin
            state_d = ACCESS;
            idx_d   = hit_idx;
            wdt_clr = 1'b1;
          end else
            state_d = ERROR;
        end
      end
      ACCESS: begin
        if (!cpu_as)     state_d = IDLE;
        else if (acc_ack) state_d = RELEASE;
        else if (expired) state_d = ERROR;
      end
      ERROR, RELEASE: if (!cpu_as) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sel_raw  = dout_arr[idx_q];
  assign sel_data = BYTE_DUP[idx_q] ? {sel_raw[7:0], sel_raw[7:0]} : sel_raw;

  // Outputs are forced low while reset is sampled so a mid-cycle reset clears at once.
  always_comb begin
    cpu_bus_ack = 1'b0;
    cpu_bus_err = 1'b0;
    cpu_data_in = '0;
    slave_cs    = '0;
    fabric_busy = 1'b0;
    if (!reset) begin
      fabric_busy = (state_q != IDLE);
      cpu_bus_err = (state_q == ERROR);
      cpu_bus_ack = acc_ack || (state_q == RELEASE) || ((state_q == IDLE) && cpu_iack);
      if (hit && !cpu_iack)
        slave_cs = NUM_SLAVES'(1) << hit_idx;
      if (cpu_iack && (state_q == IDLE || state_q == RELEASE))
        cpu_data_in = dout_arr[IACK_SLAVE];
      else if (state_q == ACCESS || state_q == RELEASE)
        cpu_data_in = sel_data;
    end
  end

`ifdef ATTEX_BUS_ERR_CAPTURE_EN
  // Capture the faulting address and cause on every entry into ERROR.
  always_ff @(posedge clk30) begin
    if (reset) begin
      err_addr        <= '0;
      err_was_timeout <= 1'b0;
      err_count       <= '0;
    end else if ((state_q != ERROR) && (state_d == ERROR)) begin
      err_addr        <= addr_byte;
      err_was_timeout <= (state_q == ACCESS);
      if (err_count != '1)
        err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_attex_bus_fabric.sv
// Directed bench for attex_bus_fabric with five regions at 0x00/0x10/0x30/0x40/0x50 (x 64K).
module tb_attex_bus_fabric;

  logic              clk30 = 1'b0;
  logic              reset;
  logic [23:1]       cpu_addr;
  logic              cpu_as, cpu_uds, cpu_lds, cpu_write_strobe, cpu_iack;
  logic [15:0]       cpu_data_in;
  logic              cpu_bus_ack, cpu_bus_err, fabric_busy;
  logic [4:0]        slave_cs;
  logic [4:0][15:0]  sdout;
  logic [4:0]        sack;
`ifdef ATTEX_BUS_ERR_CAPTURE_EN
  logic [23:0]       err_addr;
  logic              err_was_timeout;
  logic [7:0]        err_count;
`endif

  int n_chk = 0;
  int n_fail = 0;

  attex_bus_fabric #(
    .NUM_SLAVES     (5),
    .REGION_BASE    ({24'h500000, 24'h400000, 24'h300000, 24'h100000, 24'h000000}),
    .REGION_MASK    ({5{24'hff0000}}),
    .BYTE_DUP       (5'b10000),
    .MIN_WAIT       ({4'd0, 4'd0, 4'd0, 4'd0, 4'd3}),
    .TIMEOUT_CYCLES (16),
    .IACK_SLAVE     (1)
  ) dut (
    .clk30            (clk30),
    .reset            (reset),
    .cpu_addr         (cpu_addr),
    .cpu_as           (cpu_as),
    .cpu_uds          (cpu_uds),
    .cpu_lds          (cpu_lds),
    .cpu_write_strobe (cpu_write_strobe),
    .cpu_iack         (cpu_iack),
    .cpu_data_in      (cpu_data_in),
    .cpu_bus_ack      (cpu_bus_ack),
    .cpu_bus_err      (cpu_bus_err),
    .slave_cs         (slave_cs),
    .slave_dout       (sdout),
    .slave_ack        (sack),
    .fabric_busy      (fabric_busy)
`ifdef ATTEX_BUS_ERR_CAPTURE_EN
    ,
    .err_addr         (err_addr),
    .err_was_timeout  (err_was_timeout),
    .err_count        (err_count)
`endif
  );

  always #5 clk30 = ~clk30;

  task automatic nxt;
    @(posedge clk30); #1;
  endtask

  task automatic smp;
    @(negedge clk30);
  endtask

  task automatic set_addr(input logic [23:0] a);
    cpu_addr = a[23:1];
  endtask

  // Finish the current cycle: one edge with AS still high, then idle the bus.
  task automatic bus_drop;
    nxt;
    cpu_as = 0; cpu_uds = 0; cpu_lds = 0; cpu_iack = 0; sack = '0;
    nxt; nxt;
  endtask

  task automatic test_reset;
    reset = 1;
    nxt; nxt; smp;
    n_chk++; if (cpu_bus_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got=%b exp=0", cpu_bus_ack); end
    n_chk++; if (cpu_bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", cpu_bus_err); end
    n_chk++; if (slave_cs !== 5'b0) begin n_fail++; $display("FAIL rst_cs got=%b exp=00000", slave_cs); end
    n_chk++; if (cpu_data_in !== 16'h0) begin n_fail++; $display("FAIL rst_data got=%h exp=0000", cpu_data_in); end
    n_chk++; if (fabric_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", fabric_busy); end
`ifdef ATTEX_BUS_ERR_CAPTURE_EN
    n_chk++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL rst_errcnt got=%0d exp=0", err_count); end
`endif
    nxt;
    reset = 0;
  endtask

  // Slave 2 acks on its third ACCESS cycle; cs is up before the strobes.
  task automatic test_read_slave2;
    set_addr(24'h300010); cpu_as = 1;
    smp;
    n_chk++; if (slave_cs !== 5'b00100) begin n_fail++; $display("FAIL s2_cs_early got=%b exp=00100", slave_cs); end
    n_chk++; if (fabric_busy !== 1'b0) begin n_fail++; $display("FAIL s2_busy_idle got=%b exp=0", fabric_busy); end
    nxt; cpu_uds = 1; cpu_lds = 1;
    smp;
    n_chk++; if (cpu_bus_ack !== 1'b0) begin n_fail++; $display("FAIL s2_ack_idle got=%b exp=0", cpu_bus_ack); end
    nxt; smp;
    n_chk++; if (fabric_busy !== 1'b1) begin n_fail++; $display("FAIL s2_busy got=%b exp=1", fabric_busy); end
    n_chk++; if (cpu_data_in !== 16'hBEEF) begin n_fail++; $display("FAIL s2_data1 got=%h exp=beef", cpu_data_in); end
    n_chk++; if (cpu_bus_ack !== 1'b0) begin n_fail++; $display("FAIL s2_ack_c1 got=%b exp=0", cpu_bus_ack); end
    nxt; smp;
    n_chk++; if (cpu_bus_ack !== 1'b0) begin n_fail++; $display("FAIL s2_ack_c2 got=%b exp=0", cpu_bus_ack); end
    nxt; sack[2] = 1;
    smp;
    n_chk++; if (cpu_bus_ack !== 1'b1) begin n_fail++; $display("FAIL s2_ack_c3 got=%b exp=1", cpu_bus_ack); end
    n_chk++; if (cpu_data_in !== 16'hBEEF) begin n_fail++; $display("FAIL s2_data3 got=%h exp=beef", cpu_data_in); end
    n_chk++; if (slave_cs !== 5'b00100) begin n_fail++; $display("FAIL s2_cs got=%b exp=00100", slave_cs); end
    nxt; sack[2] = 0;
    smp;
    n_chk++; if (cpu_bus_ack !== 1'b1) begin n_fail++; $display("FAIL s2_ack_release got=%b exp=1", cpu_bus_ack); end
    bus_drop; smp;
    n_chk++; if (fabric_busy !== 1'b0) begin n_fail++; $display("FAIL s2_busy_end got=%b exp=0", fabric_busy); end
    n_chk++; if (cpu_data_in !== 16'h0) begin n_fail++; $display("FAIL s2_data_end got=%h exp=0000", cpu_data_in); end
  endtask

  // Slave 0 has a 3-cycle minimum wait: ack tied high, honoured at counter 3.
  task automatic test_min_wait;
    nxt;
    set_addr(24'h000100); sack[0] = 1; cpu_as = 1; cpu_uds = 1;
    smp;
    n_chk++; if (cpu_bus_ack !== 1'b0) begin n_fail++; $display("FAIL mw_ack_idle got=%b exp=0", cpu_bus_ack); end
    for (int k = 0; k < 4; k++) begin
      nxt; smp;
      n_chk++; if (cpu_bus_ack !== (k == 3)) begin n_fail++; $display("FAIL mw_ack_c%0d got=%b exp=%b", k, cpu_bus_ack, (k == 3)); end
    end
    bus_drop;
  endtask

  // Unmapped address: error one cycle after the strobes, held until AS drops.
  task automatic test_unmapped;
    set_addr(24'h600000); cpu_as = 1; cpu_lds = 1;
    smp;
    n_chk++; if (cpu_bus_err !== 1'b0) begin n_fail++; $display("FAIL um_err_idle got=%b exp=0", cpu_bus_err); end
    n_chk++; if (slave_cs !== 5'b0) begin n_fail++; $display("FAIL um_cs got=%b exp=00000", slave_cs); end
    nxt; smp;
    n_chk++; if (cpu_bus_err !== 1'b1) begin n_fail++; $display("FAIL um_err got=%b exp=1", cpu_bus_err); end
    n_chk++; if (cpu_bus_ack !== 1'b0) begin n_fail++; $display("FAIL um_ack got=%b exp=0", cpu_bus_ack); end
`ifdef ATTEX_BUS_ERR_CAPTURE_EN
    n_chk++; if (err_addr !== 24'h600000) begin n_fail++; $display("FAIL um_erraddr got=%h exp=600000", err_addr); end
    n_chk++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL um_errcnt got=%0d exp=1", err_count); end
    n_chk++; if (err_was_timeout !== 1'b0) begin n_fail++; $display("FAIL um_errtmo got=%b exp=0", err_was_timeout); end
`endif
    nxt; smp;
    n_chk++; if (cpu_bus_err !== 1'b1) begin n_fail++; $display("FAIL um_err_hold got=%b exp=1", cpu_bus_err); end
    nxt; cpu_as = 0; cpu_lds = 0;
    smp;
    n_chk++; if (cpu_bus_err !== 1'b1) begin n_fail++; $display("FAIL um_err_asfall got=%b exp=1", cpu_bus_err); end
    nxt; smp;
    n_chk++; if (cpu_bus_err !== 1'b0) begin n_fail++; $display("FAIL um_err_end got=%b exp=0", cpu_bus_err); end
    nxt;
  endtask

  // Slave 3 never acks; counter reaches 16 on the 17th ACCESS cycle, ERROR follows.
  task automatic test_timeout;
    set_addr(24'h400000); cpu_as = 1; cpu_uds = 1; cpu_lds = 1;
    nxt;
    for (int k = 0; k <= 16; k++) begin
      smp;
      n_chk++; if (cpu_bus_err !== 1'b0) begin n_fail++; $display("FAIL to_err_c%0d got=%b exp=0", k, cpu_bus_err); end
      nxt;
    end
    smp;
    n_chk++; if (cpu_bus_err !== 1'b1) begin n_fail++; $display("FAIL to_err got=%b exp=1", cpu_bus_err); end
`ifdef ATTEX_BUS_ERR_CAPTURE_EN
    n_chk++; if (err_was_timeout !== 1'b1) begin n_fail++; $display("FAIL to_errtmo got=%b exp=1", err_was_timeout); end
    n_chk++; if (err_addr !== 24'h400000) begin n_fail++; $display("FAIL to_erraddr got=%h exp=400000", err_addr); end
    n_chk++; if (err_count !== 8'd2) begin n_fail++; $display("FAIL to_errcnt got=%0d exp=2", err_count); end
`endif
    bus_drop;
  endtask

  // Byte-wide slave 4: low byte appears on both lanes, nothing outside the cycle.
  task automatic test_byte_dup;
    set_addr(24'h500000); cpu_as = 1; cpu_uds = 1; cpu_lds = 1; sack[4] = 1;
    smp;
    n_chk++; if (cpu_data_in !== 16'h0) begin n_fail++; $display("FAIL bd_data_idle got=%h exp=0000", cpu_data_in); end
    nxt; smp;
    n_chk++; if (cpu_bus_ack !== 1'b1) begin n_fail++; $display("FAIL bd_ack got=%b exp=1", cpu_bus_ack); end
    n_chk++; if (cpu_data_in !== 16'h5A5A) begin n_fail++; $display("FAIL bd_data got=%h exp=5a5a", cpu_data_in); end
    bus_drop;
  endtask

  // IACK: immediate ack with the vector from slave 1, no chip-select.
  task automatic test_iack;
    set_addr(24'h100000); cpu_iack = 1; cpu_as = 1; cpu_lds = 1;
    smp;
    n_chk++; if (cpu_bus_ack !== 1'b1) begin n_fail++; $display("FAIL ia_ack got=%b exp=1", cpu_bus_ack); end
    n_chk++; if (cpu_data_in !== 16'h0042) begin n_fail++; $display("FAIL ia_data got=%h exp=0042", cpu_data_in); end
    n_chk++; if (slave_cs !== 5'b0) begin n_fail++; $display("FAIL ia_cs got=%b exp=00000", slave_cs); end
    nxt; smp;
    n_chk++; if (cpu_bus_ack !== 1'b1) begin n_fail++; $display("FAIL ia_ack_hold got=%b exp=1", cpu_bus_ack); end
    bus_drop;
  endtask

  // AS falls mid-ACCESS: a late slave ack is not passed through, FSM returns to IDLE.
  task automatic test_abort;
    set_addr(24'h300000); cpu_as = 1; cpu_uds = 1; cpu_lds = 1;
    nxt; smp;
    n_chk++; if (fabric_busy !== 1'b1) begin n_fail++; $display("FAIL ab_busy got=%b exp=1", fabric_busy); end
    nxt; cpu_as = 0; cpu_uds = 0; cpu_lds = 0; sack[2] = 1;
    smp;
    n_chk++; if (cpu_bus_ack !== 1'b0) begin n_fail++; $display("FAIL ab_ack got=%b exp=0", cpu_bus_ack); end
    n_chk++; if (cpu_bus_err !== 1'b0) begin n_fail++; $display("FAIL ab_err got=%b exp=0", cpu_bus_err); end
    nxt; sack[2] = 0;
    smp;
    n_chk++; if (fabric_busy !== 1'b0) begin n_fail++; $display("FAIL ab_busy_end got=%b exp=0", fabric_busy); end
    nxt;
  endtask

  // AS without strobes: cs only, the FSM never leaves IDLE.
  task automatic test_no_strobe;
    set_addr(24'h000000); cpu_as = 1;
    for (int k = 0; k < 3; k++) begin
      smp;
      n_chk++; if (slave_cs !== 5'b00001) begin n_fail++; $display("FAIL ns_cs_c%0d got=%b exp=00001", k, slave_cs); end
      n_chk++; if ({cpu_bus_ack, cpu_bus_err, fabric_busy} !== 3'b000) begin n_fail++; $display("FAIL ns_flags_c%0d got=%b exp=000", k, {cpu_bus_ack, cpu_bus_err, fabric_busy}); end
      nxt;
    end
    cpu_as = 0;
    nxt;
  endtask

  // Reset during ACCESS with AS still held clears every output immediately.
  task automatic test_reset_mid;
    set_addr(24'h400000); cpu_as = 1; cpu_uds = 1; cpu_lds = 1;
    nxt; nxt; smp;
    n_chk++; if (fabric_busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy_pre got=%b exp=1", fabric_busy); end
    nxt; reset = 1;
    smp;
    n_chk++; if ({cpu_bus_ack, cpu_bus_err, fabric_busy} !== 3'b000) begin n_fail++; $display("FAIL rm_flags got=%b exp=000", {cpu_bus_ack, cpu_bus_err, fabric_busy}); end
    n_chk++; if (slave_cs !== 5'b0) begin n_fail++; $display("FAIL rm_cs got=%b exp=00000", slave_cs); end
    nxt; reset = 0; cpu_as = 0; cpu_uds = 0; cpu_lds = 0;
    smp;
    n_chk++; if (fabric_busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy_post got=%b exp=0", fabric_busy); end
    n_chk++; if (cpu_data_in !== 16'h0) begin n_fail++; $display("FAIL rm_data got=%h exp=0000", cpu_data_in); end
`ifdef ATTEX_BUS_ERR_CAPTURE_EN
    n_chk++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL rm_errcnt got=%0d exp=0", err_count); end
`endif
    nxt;
  endtask

  initial begin
    reset = 1; cpu_addr = '0; cpu_as = 0; cpu_uds = 0; cpu_lds = 0;
    cpu_write_strobe = 0; cpu_iack = 0; sack = '0;
    sdout = {16'h005A, 16'h3333, 16'hBEEF, 16'h0042, 16'h1111};
    test_reset;
    test_read_slave2;
    test_min_wait;
    test_unmapped;
    test_timeout;
    test_byte_dup;
    test_iack;
    test_abort;
    test_no_strobe;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/attex_bus_fabric.md
Name: attex_bus_fabric

Overview:
- Parametrised successor to the hand-written chip-select, read-mux and bus-ack logic in the CD-i top level.
- Decodes SCC68070 bus cycles into N slave chip-selects and muxes read data and acknowledge back to the CPU.
- Inserts per-slave minimum wait states and raises bus error on unmapped or timed-out accesses.
- Provides a forced-ack path for interrupt-acknowledge cycles. Sits between scc68070 and the peripherals (mcd212, cdic, slave uC, mk48).

Parameters:
- NUM_SLAVES, 5, number of decoded regions (1..8).
- REGION_BASE, {5{24'h0}}, packed NUM_SLAVES x 24-bit byte base addresses.
- REGION_MASK, {5{24'hff0000}}, packed NUM_SLAVES x 24-bit masks. A slave matches when (addr_byte & mask) == base.
- BYTE_DUP, 5'b00110, per-slave bit: the 8-bit slave's dout[7:0] is duplicated onto both lanes.
- MIN_WAIT, {5{4'd0}}, packed NUM_SLAVES x 4-bit minimum cycles from cycle start before slave_ack is honoured.
- TIMEOUT_CYCLES, 1023, cycles in ACCESS without an ack before bus error; 0 disables the timeout.
- IACK_SLAVE, 1, index of the slave whose dout supplies the vector during IACK.

Ports:
- clk30  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- cpu_addr  in  23  word address [23:1].
- cpu_as  in  1  address strobe.
- cpu_uds  in  1  upper data strobe.
- cpu_lds  in  1  lower data strobe.
- cpu_write_strobe  in  1  write cycle.
- cpu_iack  in  1  interrupt-acknowledge cycle active.
- cpu_data_in  out  16  read data to CPU.
- cpu_bus_ack  out  1  DTACK equivalent.
- cpu_bus_err  out  1  bus error.
- slave_cs  out  NUM_SLAVES  one-hot chip-select.
- slave_dout  in  NUM_SLAVES*16  slave read data, slave i at [16i+15:16i].
- slave_ack  in  NUM_SLAVES  slave acknowledge.
- fabric_busy  out  1  high while the FSM is not IDLE.

Behaviour:
- Reset: FSM=IDLE, counter=0, latched index=0. cpu_bus_ack=0, cpu_bus_err=0, slave_cs=0, cpu_data_in=0, fabric_busy=0.
- Decode: match_i = cpu_as && ((addr_byte & MASK_i) == BASE_i), where addr_byte = {cpu_addr,1'b0}. The lowest matching index wins.
- slave_cs is combinational, one-hot and asserted whenever cpu_as is high and the address matches. It does not depend on the data strobes, so cs is valid one cycle before the strobes.
- States are IDLE, ACCESS, ERROR, RELEASE.
- IDLE -> ACCESS when cpu_as && (cpu_uds||cpu_lds) && a match exists: latch the index and clear the counter.
- IDLE -> ERROR when strobes are high with no match and cpu_iack=0.
- IDLE -> RELEASE when cpu_iack=1.
- ACCESS: the counter increments each cycle and saturates.
  - cpu_bus_ack = slave_ack[idx] && counter >= MIN_WAIT[idx], combinational (0 added latency).
  - On ack -> RELEASE.
  - When counter == TIMEOUT_CYCLES and no ack -> ERROR.
- ERROR: cpu_bus_err=1 and cpu_bus_ack=0, held until cpu_as falls, then IDLE.
- RELEASE: cpu_bus_ack held at 1 until cpu_as falls, then IDLE. Acks arriving in RELEASE are ignored.
- IACK (cpu_iack=1): overrides decode. cpu_bus_ack=1 the same cycle, cpu_data_in = slave_dout[IACK_SLAVE], slave_cs stays 0.
- Read data: cpu_data_in = slave_dout[idx], or {dout[7:0],dout[7:0]} when BYTE_DUP[idx]. It is 0 outside ACCESS, RELEASE and IACK.
- cpu_as with no strobes: cs asserted, no ack, no error, and the FSM stays IDLE.
- cpu_as falling mid-ACCESS (aborted cycle): go to IDLE next cycle. No err, no ack.
- reset mid-cycle: the FSM returns to IDLE and all outputs clear in the same cycle as reset is sampled.
- Address change while cpu_as is held: the latched index is kept until cpu_as falls.

Optional Feature:
- Macro: ATTEX_BUS_ERR_CAPTURE_EN.
- When defined, adds outputs err_addr (24 bits), err_was_timeout (1 bit) and err_count (8 bits, saturating).
  - err_addr and err_was_timeout are captured on entry to ERROR.
  - All three clear on reset.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Package attex_bus_pkg holds:
  - fabric_state_e enum (IDLE/ACCESS/ERROR/RELEASE);
  - the SLV_IDX_W = $clog2(NUM_SLAVES) helper function;
  - region-extraction functions for slicing the packed BASE/MASK/MIN_WAIT parameters.
- Sub-module bus_timeout_wdt: a saturating counter with clear, enable, min_reached and expired outputs, instantiated once.

Test Plan:
- Slave 2 (base 24'h300000, mask ff0000, MIN_WAIT 0) acks on its 3rd cycle -> cpu_bus_ack pulses the same cycle; cpu_data_in = 16'hBEEF; slave_cs=5'b00100.
- MIN_WAIT[0]=3 with slave_ack[0] tied high -> cpu_bus_ack first asserts exactly 3 cycles after the strobes rise.
- Read at 24'h600000, unmapped -> cpu_bus_err=1 one cycle after the strobes, held until cpu_as falls; with the macro, err_addr=24'h600000 and err_count=1.
- Mapped slave never acks, TIMEOUT_CYCLES=16 -> cpu_bus_err asserts on cycle 16 of ACCESS, and err_was_timeout=1.
- BYTE_DUP slave 4 returns dout=16'h005A -> cpu_data_in = 16'h5A5A.
- cpu_iack=1 with slave_dout[1]=16'h0042 -> cpu_bus_ack=1 the same cycle and cpu_data_in=16'h0042. Assert reset during ACCESS -> all outputs 0 and FSM IDLE the next edge.
